// File: rtl/sync_fifo_pkg.sv
// Shared constants, the read-mode enum and the pointer-width helper for the
// synchronous FIFO with status and sticky error flags.
package sync_fifo_pkg;

   typedef enum logic {REG_READ = 1'b0, FWFT = 1'b1} fifo_mode_e;

   localparam int AE_LEVEL_DEFAULT  = 4;
   localparam int AF_MARGIN_DEFAULT = 4;

   // Pointers carry one extra wrap bit above the address bits.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port and one
// combinational read-address port. The array is deliberately not reset.
module sfifo_ram #(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered or first-word-fall-through read, occupancy
// count, full/empty/almost flags and sticky overflow/underflow flags.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = DEPTH - AF_MARGIN_DEFAULT,
   parameter int AE_LEVEL   = AE_LEVEL_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        rd_en,
   output logic [DATA_WIDTH-1:0]       data_out,
   input  logic                        flush,
   input  logic                        clr_err,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [ptr_width(DEPTH)-1:0] count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int ADDR_W = PTR_W - 1;
   localparam fifo_mode_e MODE = (FWFT != 0) ? sync_fifo_pkg::FWFT : sync_fifo_pkg::REG_READ;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of two and at least 4");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH - 1)) begin : g_bad_af
      $error("sync_fifo_flags: AF_LEVEL must lie in 1..DEPTH-1");
   end
   if ((AE_LEVEL < 1) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_flags: AE_LEVEL must lie in 1..DEPTH-1");
   end

   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W-1:0]      wr_ptr_d, rd_ptr_d, count_d;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  wr_ok, rd_ok, capture;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // Flush takes priority and silences both requests for that cycle.
   assign wr_ok = wr_en && !full  && !flush;
   assign rd_ok = rd_en && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr;
      rd_ptr_d = rd_ptr;
      count_d  = count;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr_d = rd_ptr + PTR_ONE;
         if (wr_ok && !rd_ok) begin
            count_d = count + PTR_ONE;
         end else if (rd_ok && !wr_ok) begin
            count_d = count - PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
         count  <= count_d;
      end
   end

   // A set event outranks a simultaneous clear request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full && !flush) overflow <= 1'b1;
         else if (clr_err)            overflow <= 1'b0;
         if (rd_en && empty && !flush) underflow <= 1'b1;
         else if (clr_err)             underflow <= 1'b0;
      end
   end

   sfifo_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (ram_rd_data)
   );

   // In FWFT mode the register tracks the presented head so the output can
   // hold the last shown word once the FIFO runs empty.
   assign capture = (MODE == sync_fifo_pkg::FWFT) ? !empty : rd_ok;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
      end else if (capture) begin
         data_q <= ram_rd_data;
      end
   end

   assign data_out = ((MODE == sync_fifo_pkg::FWFT) && !empty) ? ram_rd_data : data_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench: a registered-read FIFO (DEPTH=8, AF=6, AE=2)
// and a FWFT FIFO share one stimulus stream.
module tb_sync_fifo_flags;

   localparam int DEPTH = 8;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          flush = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] data_out, fw_data_out;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic          fw_full, fw_empty, fw_almost_full, fw_almost_empty, fw_overflow, fw_underflow;
   logic [3:0]    count, fw_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)
   ) dut (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .flush(flush), .clr_err(clr_err), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flags #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)
   ) dut_fw (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(fw_data_out), .flush(flush), .clr_err(clr_err), .full(fw_full),
      .empty(fw_empty), .almost_full(fw_almost_full), .almost_empty(fw_almost_empty),
      .count(fw_count), .overflow(fw_overflow), .underflow(fw_underflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rstn = 1'b0;
      #3;
      total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin bad++; $display("[TB] FAIL reset_flags got=%b want=1010", {empty, full, almost_empty, almost_full}); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
      total++; if ({overflow, underflow} !== 2'b00 || data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_err_data got=%b/%h want=00/00", {overflow, underflow}, data_out); end
      @(negedge clk);
      rstn = 1'b1;
      step();
   endtask

   task automatic test_fill_flags();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 8'h10 + 8'(i);
         step();
         total++; if (count !== 4'(i + 1)) begin bad++; $display("[TB] FAIL fill_count got=%0d want=%0d", count, i + 1); end
         total++; if (almost_full !== (i + 1 >= 6)) begin bad++; $display("[TB] FAIL fill_af got=%b want=%b at count %0d", almost_full, (i + 1 >= 6), i + 1); end
         total++; if (almost_empty !== (i + 1 <= 2)) begin bad++; $display("[TB] FAIL fill_ae got=%b want=%b at count %0d", almost_empty, (i + 1 <= 2), i + 1); end
      end
      total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL fill_full got=%b/%b want=1/0", full, overflow); end
      data_in = 8'h99; rd_en = 1'b1;
      step();
      rd_en = 1'b0; wr_en = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow_set got=%b want=1", overflow); end
      // The read on that full cycle was accepted, so occupancy drops to 7.
      total++; if (count !== 4'd7 || data_out !== 8'h10) begin bad++; $display("[TB] FAIL full_gate got=%0d/%h want=7/10", count, data_out); end
      wr_en = 1'b1; data_in = 8'h18;
      step();
      wr_en = 1'b1; data_in = 8'h9A;
      step();
      wr_en = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL ninth_write_count got=%0d want=8", count); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         step();
         total++; if (data_out !== 8'h11 + 8'(i)) begin bad++; $display("[TB] FAIL drain_data got=%h want=%h", data_out, 8'h11 + 8'(i)); end
      end
      total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty got=%b/%b want=1/0", empty, underflow); end
      step();
      rd_en = 1'b0;
      total++; if (underflow !== 1'b1 || data_out !== 8'h18) begin bad++; $display("[TB] FAIL underflow_set got=%b/%h want=1/18", underflow, data_out); end
      rd_en = 1'b1; clr_err = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (underflow !== 1'b1 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL set_beats_clear got=%b/%b want=1/0", underflow, overflow); end
      step();
      clr_err = 1'b0;
      total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL clr_err got=%b want=0", underflow); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; data_in = 8'h20 + 8'(i);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h24 + 8'(i);
         step();
         total++; if (count !== 4'd4 || data_out !== 8'h20 + 8'(i)) begin bad++; $display("[TB] FAIL b2b got=%0d/%h want=4/%h", count, data_out, 8'h20 + 8'(i)); end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (data_out !== 8'h34 + 8'(i)) begin bad++; $display("[TB] FAIL b2b_tail got=%h want=%h", data_out, 8'h34 + 8'(i)); end
      end
      rd_en = 1'b0;
      total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got=%b/%b want=1/0", empty, underflow); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; data_in = 8'h40 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         step();
      end
      rd_en = 1'b0;
      total++; if (count !== 4'd5 || overflow !== 1'b1 || data_out !== 8'h42) begin bad++; $display("[TB] FAIL preflush got=%0d/%b/%h want=5/1/42", count, overflow, data_out); end
      flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
      step();
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_count got=%0d/%b want=0/1", count, empty); end
      total++; if (overflow !== 1'b1 || underflow !== 1'b0 || data_out !== 8'h42) begin bad++; $display("[TB] FAIL flush_keep got=%b/%b/%h want=1/0/42", overflow, underflow, data_out); end
      wr_en = 1'b1; data_in = 8'h50;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (data_out !== 8'h50 || empty !== 1'b1) begin bad++; $display("[TB] FAIL post_flush got=%h/%b want=50/1", data_out, empty); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL flush_clr got=%b want=0", overflow); end
   endtask

   task automatic test_fwft();
      test_reset();
      wr_en = 1'b1; data_in = 8'hA5;
      step();
      wr_en = 1'b0;
      total++; if (fw_empty !== 1'b0 || fw_data_out !== 8'hA5) begin bad++; $display("[TB] FAIL fwft_head got=%b/%h want=0/a5", fw_empty, fw_data_out); end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (fw_empty !== 1'b1 || fw_data_out !== 8'hA5) begin bad++; $display("[TB] FAIL fwft_hold got=%b/%h want=1/a5", fw_empty, fw_data_out); end
      wr_en = 1'b1; data_in = 8'h11;
      step();
      data_in = 8'h22;
      step();
      wr_en = 1'b0;
      total++; if (fw_data_out !== 8'h11 || fw_count !== 4'd2) begin bad++; $display("[TB] FAIL fwft_first got=%h/%0d want=11/2", fw_data_out, fw_count); end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (fw_data_out !== 8'h22) begin bad++; $display("[TB] FAIL fwft_advance got=%h want=22", fw_data_out); end
   endtask

   task automatic test_async_reset();
      wr_en = 1'b1; data_in = 8'h61;
      step();
      data_in = 8'h62;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("[TB] FAIL async_flags got=%0d/%b%b%b%b want=0/1010", count, empty, full, almost_empty, almost_full); end
      total++; if (data_out !== 8'h00 || fw_empty !== 1'b1) begin bad++; $display("[TB] FAIL async_data got=%h/%b want=00/1", data_out, fw_empty); end
      #2 rstn = 1'b1;
      step();
      wr_en = 1'b1; data_in = 8'h77;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (data_out !== 8'h77 || empty !== 1'b1) begin bad++; $display("[TB] FAIL async_readback got=%h/%b want=77/1", data_out, empty); end
   endtask

   initial begin
      test_reset();
      test_fill_flags();
      test_drain();
      test_back_to_back();
      test_flush();
      test_fwft();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of entries, a power of two and at least 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width in bits.
REQ-003 The block SHALL have parameter FWFT, default 0, where 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-4, the almost-full threshold, legal range 1..DEPTH-1.
REQ-005 The block SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold, legal range 1..DEPTH-1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-008 The block SHALL have port wr_en, input, 1 bit, the write request.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit, the read request.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits, the read data.
REQ-012 The block SHALL have port flush, input, 1 bit, a synchronous content clear.
REQ-013 The block SHALL have port clr_err, input, 1 bit, which clears the sticky error flags.
REQ-014 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit, the status flags.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the current occupancy.
REQ-016 The block SHALL have ports overflow and underflow, each output, 1 bit, the sticky error flags.

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and full=0; a read SHALL be accepted iff rd_en=1 and empty=0.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH)+1 bits with an MSB wrap bit, and SHALL roll over modulo 2*DEPTH.
REQ-019 count SHALL be a register: +1 on write only, -1 on read only, unchanged on a simultaneous accepted write and read.
REQ-020 The flags SHALL decode combinationally from the count register: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-021 full gates writes even when rd_en=1 in the same cycle; that write SHALL be dropped and SHALL count as an overflow.
REQ-022 If empty=1, a simultaneous wr_en and rd_en SHALL accept the write only; there is no bypass.
REQ-023 With FWFT=0, data_out SHALL be registered and update one cycle after an accepted read, holding its value otherwise.
REQ-024 With FWFT=1, data_out SHALL present the head entry combinationally whenever empty=0, and an accepted read SHALL advance to the next entry in the following cycle.
REQ-025 With FWFT=1 and empty=1, data_out SHALL hold the last value presented.
REQ-026 overflow SHALL be set on wr_en=1 with full=1; underflow SHALL be set on rd_en=1 with empty=1.
REQ-027 Each sticky flag SHALL stay set until clr_err=1; if a set event and clr_err=1 occur in the same cycle, the set event SHALL win.
REQ-028 flush=1 SHALL zero both pointers and count at the next edge.
REQ-029 During a flush cycle, wr_en and rd_en SHALL be ignored and SHALL raise no error.
REQ-030 A flush SHALL leave overflow, underflow and data_out unchanged.
REQ-031 Memory contents SHALL never be read out past the write pointer; stale data SHALL be unobservable.

Reset
REQ-032 While rstn=0, pointers, count, overflow, underflow and the data_out register SHALL be 0 immediately (asynchronously).
REQ-033 Reset values SHALL be: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-034 Reset asserted mid-operation SHALL discard all contents; the storage array itself SHALL NOT be reset.
REQ-035 Reset deassertion SHALL be assumed synchronous to clk by the integrator; no internal synchronizer SHALL be added.

Structure
REQ-036 Package sync_fifo_pkg SHALL hold the ptr-width function, the default threshold constants and a mode enum {REG_READ, FWFT}.
REQ-037 The storage SHALL be a sub-module sfifo_ram: a DEPTH x DATA_WIDTH array with one write port and one read-address port; the array SHALL NOT be reset.
REQ-038 Parameter legality (power-of-two DEPTH, threshold ranges) SHALL be checked by elaboration-time assertions.

Verification
REQ-039 DEPTH=8, FWFT=0: write 8 words 0x10..0x17 -> full=1 after the 8th edge; a 9th write sets overflow=1 and count stays 8.
REQ-040 From full, read 8 words -> data_out 0x10..0x17, each one cycle after its rd_en; then empty=1; a further rd_en sets underflow=1.
REQ-041 FWFT=1: single write of 0xA5 -> empty=0 and data_out=0xA5 the next cycle with no rd_en; rd_en -> empty=1.
REQ-042 Count of 4, simultaneous wr_en/rd_en for 20 cycles -> count stays 4, pointers wrap correctly, read-data order preserved.
REQ-043 Flags: AF_LEVEL=6, AE_LEVEL=2 -> almost_full asserts at count 6 and almost_empty deasserts at count 3.
REQ-044 Flush at count 5 while overflow=1 -> count=0 and empty=1 next cycle with overflow still 1; then clr_err=1 -> overflow=0.
REQ-045 Mid-stream rstn pulse (not clock-aligned) -> all outputs take reset values immediately, and a write after release reads back correctly.
